mips_load_store_unit: RTL and testbench
=======================================

# mips_load_store_unit

Sequential load/store unit between the datapath (ALU address result, rt store data, control decode) and the word-organised data memory. Converts byte-addressed lw/lh/lhu/lb/lbu/sw/sh/sb requests into word-wide memory cycles. Sub-word stores use a read-modify-write sequence. Misaligned and out-of-range accesses are flagged. The core stalls on `ls_busy` until `ls_done`.

## Interface
- No parameters. Memory depth is fixed at 128 words (7-bit word address, 512 bytes).
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ls_req  in  1  access request, sampled only in IDLE
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
- ls_unsigned  in  1  zero-extend loads (lbu/lhu); ignored for word and stores
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data; sub-word data is taken from the low bits
- ls_rdata  out  32  load result, registered
- ls_busy  out  1  high in every state except IDLE
- ls_done  out  1  one-cycle completion pulse
- ls_err  out  1  qualifies `ls_done`: misaligned, out-of-range or reserved size
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- DM_addr  out  7  word address, equal to `ls_addr[8:2]` of the accepted request
- DM_Write_data  out  32  word to write
- DM_Read_data  in  32  combinational read data, valid in the same cycle as `MemRead`

## Operation
- **Memory contract:**
  - Read is combinational while MemRead=1 and MemWrite=0.
  - Write commits at the rising edge while MemWrite=1 and MemRead=0.
  - This block never asserts MemRead and MemWrite together; both are 0 in IDLE and DONE.
- **Lanes:** little-endian. Byte k sits at bits [8k+7:8k]. A halfword at offset 0 sits at [15:0]; at offset 2 it sits at [31:16].
- **Acceptance:** in IDLE with `ls_req`=1, the unit latches addr, size, we, unsigned and wdata. `ls_req` in any other state is ignored; the core holds it.
- **Error check (at accept):**
  - half with addr[0]≠0
  - word with addr[1:0]≠0
  - addr[31:9]≠0
  - size=11
  - On error: go to DONE with `ls_err`=1, no memory cycle, `ls_rdata` unchanged.
- **States:**
  - IDLE
  - LOAD: MemRead=1; lane extract plus sign/zero extension written to `ls_rdata` at the edge; then DONE.
  - STORE_W: word store; MemWrite=1 with DM_Write_data=wdata; then DONE.
  - RMW_RD: sub-word store; MemRead=1; full word captured into the merge register; then RMW_WR.
  - RMW_WR: MemWrite=1 with DM_Write_data = merge register with the target lane(s) replaced; then DONE.
  - DONE: `ls_done`=1 for one cycle; always returns to IDLE.
- **Extension:**
  - lb/lh replicate bit 7 / bit 15.
  - lbu/lhu zero-fill.
  - lw passes the word through.
- **Reset (rst=0, any time):**
  - State goes to IDLE immediately.
  - All outputs go to 0: ls_rdata, ls_busy, ls_done, ls_err, MemRead, MemWrite, DM_addr, DM_Write_data.
  - An in-flight RMW_WR write is aborted because MemWrite falls asynchronously, so memory is not written.

## Timing
- Request accepted at edge 0.
- Load or word store: access in cycle 1, `ls_done` in cycle 2.
- Sub-word store: RMW_RD in cycle 1, RMW_WR in cycle 2, `ls_done` in cycle 3.
- Error: `ls_done` with `ls_err` in cycle 1.
- `ls_rdata` is valid from the DONE cycle and holds until the next completed load.
- `ls_busy` rises in cycle 1 and falls after DONE. The earliest next accept is the edge ending DONE+1 (IDLE cycle).
- DM_addr, DM_Write_data, MemRead and MemWrite are driven from registered state; no combinational path from ls_* inputs to memory outputs.

## Structure
- Shared package `mips_ls_pkg`:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum: IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, DONE
  - DM_AW=7
- One combinational sub-module, `ls_lane_align`:
  - load extract/extend: word, offset, size, unsigned → 32-bit result
  - store merge: old word, wdata, offset, size → merged word
- The FSM and registers stay in the top module.

## Test plan
- Bench memory model preloaded with word n = n, except word 3 = 0x80FF1234.
- lw addr 0x10 → MemRead high exactly in cycle 1 with DM_addr=4; `ls_done` in cycle 2; `ls_rdata`=0x00000004; `ls_err`=0.
- lb 0x0F → 0xFFFFFF80; lbu 0x0F → 0x00000080; lh 0x0E → 0xFFFF80FF; lhu 0x0C → 0x00001234.
- sb addr 0x0D, wdata 0x000000AB → MemRead cycle 1, MemWrite cycle 2 with DM_Write_data=0x80FFAB34, `ls_done` cycle 3; sh 0x0E, wdata 0x5555 → word 3 = 0x5555AB34.
- lw 0x06, sh 0x0B, size=11, and lw 0x200 → each gives `ls_done` with `ls_err`=1 in cycle 1, MemRead/MemWrite never asserted, `ls_rdata` unchanged.
- rst=0 asserted mid-RMW_WR of sb 0x0C (0xEE) → MemWrite drops immediately, word 3 unchanged, all outputs 0; after release, lw 0x0C → 0x80FF1234.
- `ls_req` held continuously across two lw requests → second accepted only in the IDLE cycle after DONE; no overlapping MemRead pulses.

Source files
------------

// File: rtl/mips_ls_pkg.sv
// Shared types for the MIPS load/store unit.
// Size encodings, FSM states and the data-memory address width.
package mips_ls_pkg;

    localparam int DM_AW = 7;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } ls_size_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_W,
        RMW_RD,
        RMW_WR,
        DONE
    } ls_state_e;

endpackage

// File: rtl/mips_load_store_unit_if.sv
// Datapath-side request bundle and data-memory bus of the load/store unit.
// master = core plus memory, slave = the load/store unit.
interface mips_load_store_unit_if;
    import mips_ls_pkg::*;

    logic             ls_req;
    logic             ls_we;
    logic [1:0]       ls_size;
    logic             ls_unsigned;
    logic [31:0]      ls_addr;
    logic [31:0]      ls_wdata;
    logic [31:0]      ls_rdata;
    logic             ls_busy;
    logic             ls_done;
    logic             ls_err;
    logic             MemRead;
    logic             MemWrite;
    logic [DM_AW-1:0] DM_addr;
    logic [31:0]      DM_Write_data;
    logic [31:0]      DM_Read_data;

    modport master (
        output ls_req, ls_we, ls_size, ls_unsigned,
        output ls_addr, ls_wdata, DM_Read_data,
        input  ls_rdata, ls_busy, ls_done, ls_err,
        input  MemRead, MemWrite, DM_addr, DM_Write_data
    );

    modport slave (
        input  ls_req, ls_we, ls_size, ls_unsigned,
        input  ls_addr, ls_wdata, DM_Read_data,
        output ls_rdata, ls_busy, ls_done, ls_err,
        output MemRead, MemWrite, DM_addr, DM_Write_data
    );

endinterface

// File: rtl/ls_lane_align.sv
// Little-endian lane extraction with sign/zero extension for loads,
// and lane merge of store data into an existing word for sub-word stores.
module ls_lane_align
    import mips_ls_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  ls_size_e    size,
    input  logic        uns,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [4:0]  bit_ofs;

    assign bit_ofs = {offset, 3'b000};
    assign lane_b  = word[bit_ofs +: 8];
    assign lane_h  = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = word;
        unique case (size)
            SZ_BYTE: load_data = {{24{~uns & lane_b[7]}}, lane_b};
            SZ_HALF: load_data = {{16{~uns & lane_h[15]}}, lane_h};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_data = wdata;
        unique case (size)
            SZ_BYTE: begin
                store_data = old_word;
                store_data[bit_ofs +: 8] = wdata[7:0];
            end
            SZ_HALF: store_data = offset[1]
                ? {wdata[15:0], old_word[15:0]}
                : {old_word[31:16], wdata[15:0]};
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// Sequential load/store unit: byte-addressed requests to word memory cycles,
// with read-modify-write for sub-word stores and error flagging at accept.
module mips_load_store_unit
    import mips_ls_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    mips_load_store_unit_if.slave bus
);

    ls_state_e   state_q, state_d;
    logic [8:0]  addr_q;
    ls_size_e    size_q;
    logic        uns_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic        accept;
    logic        acc_err;

    assign accept = (state_q == IDLE) && bus.ls_req;

    // Anything outside the 512-byte window or not naturally aligned.
    assign acc_err = (bus.ls_addr[31:9] != '0)
                  || (bus.ls_size == SZ_RSVD)
                  || (bus.ls_size == SZ_HALF && bus.ls_addr[0])
                  || (bus.ls_size == SZ_WORD && bus.ls_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ls_req) begin
                    if (acc_err)                     state_d = DONE;
                    else if (!bus.ls_we)             state_d = LOAD;
                    else if (bus.ls_size == SZ_WORD) state_d = STORE_W;
                    else                             state_d = RMW_RD;
                end
            end
            LOAD:    state_d = DONE;
            STORE_W: state_d = DONE;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.ls_addr[8:0];
                size_q  <= ls_size_e'(bus.ls_size);
                uns_q   <= bus.ls_unsigned;
                err_q   <= acc_err;
                wdata_q <= bus.ls_wdata;
            end
            if (state_q == LOAD)   rdata_q <= load_data;
            if (state_q == RMW_RD) merge_q <= bus.DM_Read_data;
        end
    end

    ls_lane_align u_align (
        .word       (bus.DM_Read_data),
        .old_word   (merge_q),
        .wdata      (wdata_q),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .uns        (uns_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    assign bus.ls_rdata = rdata_q;
    assign bus.ls_busy  = (state_q != IDLE);
    assign bus.ls_done  = (state_q == DONE);
    assign bus.ls_err   = (state_q == DONE) && err_q;
    assign bus.MemRead  = (state_q == LOAD) || (state_q == RMW_RD);
    assign bus.MemWrite = (state_q == STORE_W) || (state_q == RMW_WR);
    assign bus.DM_addr  = addr_q[8:2];

    always_comb begin
        bus.DM_Write_data = '0;
        if (state_q == STORE_W)     bus.DM_Write_data = wdata_q;
        else if (state_q == RMW_WR) bus.DM_Write_data = store_data;
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit with a word memory model
// preloaded word n = n, word 3 = 0x80FF1234.
module tb_mips_load_store_unit;

    logic clk;
    logic rst;
    logic reload;
    int   checks;
    int   errors;

    logic [31:0] mem [128];

    mips_load_store_unit_if bus ();

    mips_load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.DM_Read_data = mem[bus.DM_addr];

    always @(posedge clk) begin
        if (reload) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'(i);
            mem[3] <= 32'h80FF1234;
        end else if (bus.MemWrite && !bus.MemRead) begin
            mem[bus.DM_addr] <= bus.DM_Write_data;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from an IDLE cycle and trace it to ls_done.
    task automatic run(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd,
                       output int done_cyc,
                       output logic [7:0] rd_mask,
                       output logic [7:0] wr_mask,
                       output logic [6:0] addr1,
                       output logic [31:0] wr_word,
                       output logic err);
        bus.ls_req      = 1'b1;
        bus.ls_we       = we;
        bus.ls_size     = sz;
        bus.ls_unsigned = uns;
        bus.ls_addr     = a;
        bus.ls_wdata    = wd;
        done_cyc = -1;
        rd_mask  = '0;
        wr_mask  = '0;
        addr1    = '0;
        wr_word  = '0;
        err      = 1'b0;
        for (int c = 1; c < 8 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            bus.ls_req = 1'b0;
            if (c == 1) addr1 = bus.DM_addr;
            if (bus.MemRead)  rd_mask[c] = 1'b1;
            if (bus.MemWrite) begin
                wr_mask[c] = 1'b1;
                wr_word    = bus.DM_Write_data;
            end
            if (bus.ls_done) begin
                done_cyc = c;
                err      = bus.ls_err;
            end
        end
        @(posedge clk); #1;
    endtask

    int          dc;
    logic [7:0]  rm, wm;
    logic [6:0]  a1;
    logic [31:0] ww;
    logic        er;
    logic [7:0]  hold_rd, hold_dn;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        reload = 1'b1;
        bus.ls_req      = 1'b0;
        bus.ls_we       = 1'b0;
        bus.ls_size     = 2'b10;
        bus.ls_unsigned = 1'b0;
        bus.ls_addr     = '0;
        bus.ls_wdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(bus.ls_busy),  32'd0);
        chk("rst_done",  32'(bus.ls_done),  32'd0);
        chk("rst_err",   32'(bus.ls_err),   32'd0);
        chk("rst_mrd",   32'(bus.MemRead),  32'd0);
        chk("rst_mwr",   32'(bus.MemWrite), 32'd0);
        chk("rst_addr",  32'(bus.DM_addr),  32'd0);
        chk("rst_wdat",  bus.DM_Write_data, 32'd0);
        chk("rst_rdata", bus.ls_rdata,      32'd0);
        rst    = 1'b1;
        reload = 1'b0;
        @(posedge clk); #1;

        run(1'b0, 2'b10, 1'b0, 32'h10, 0, dc, rm, wm, a1, ww, er);
        chk("lw_done",  32'(dc), 32'd2);
        chk("lw_rd",    32'(rm), 32'h02);
        chk("lw_wr",    32'(wm), 32'h00);
        chk("lw_addr",  32'(a1), 32'd4);
        chk("lw_data",  bus.ls_rdata, 32'h00000004);
        chk("lw_err",   32'(er), 32'd0);

        run(1'b0, 2'b00, 1'b0, 32'h0F, 0, dc, rm, wm, a1, ww, er);
        chk("lb_data",  bus.ls_rdata, 32'hFFFFFF80);
        run(1'b0, 2'b00, 1'b1, 32'h0F, 0, dc, rm, wm, a1, ww, er);
        chk("lbu_data", bus.ls_rdata, 32'h00000080);
        run(1'b0, 2'b01, 1'b0, 32'h0E, 0, dc, rm, wm, a1, ww, er);
        chk("lh_data",  bus.ls_rdata, 32'hFFFF80FF);
        run(1'b0, 2'b01, 1'b1, 32'h0C, 0, dc, rm, wm, a1, ww, er);
        chk("lhu_data", bus.ls_rdata, 32'h00001234);

        run(1'b1, 2'b00, 1'b0, 32'h0D, 32'hAB, dc, rm, wm, a1, ww, er);
        chk("sb_done",  32'(dc), 32'd3);
        chk("sb_rd",    32'(rm), 32'h02);
        chk("sb_wr",    32'(wm), 32'h04);
        chk("sb_wdat",  ww, 32'h80FFAB34);
        chk("sb_mem",   mem[3], 32'h80FFAB34);
        chk("sb_err",   32'(er), 32'd0);

        run(1'b1, 2'b01, 1'b0, 32'h0E, 32'h5555, dc, rm, wm, a1, ww, er);
        chk("sh_done",  32'(dc), 32'd3);
        chk("sh_mem",   mem[3], 32'h5555AB34);

        run(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, dc, rm, wm, a1, ww, er);
        chk("sw_done",  32'(dc), 32'd2);
        chk("sw_rd",    32'(rm), 32'h00);
        chk("sw_wr",    32'(wm), 32'h02);
        chk("sw_mem",   mem[8], 32'hDEADBEEF);

        run(1'b0, 2'b10, 1'b0, 32'h06, 0, dc, rm, wm, a1, ww, er);
        chk("elw_done", 32'(dc), 32'd1);
        chk("elw_err",  32'(er), 32'd1);
        chk("elw_mem",  32'({rm, wm}), 32'd0);
        chk("elw_data", bus.ls_rdata, 32'h00001234);
        run(1'b1, 2'b01, 1'b0, 32'h0B, 32'h77, dc, rm, wm, a1, ww, er);
        chk("esh_done", 32'(dc), 32'd1);
        chk("esh_err",  32'(er), 32'd1);
        chk("esh_mem",  32'({rm, wm}), 32'd0);
        chk("esh_word", mem[2], 32'd2);
        run(1'b0, 2'b11, 1'b0, 32'h10, 0, dc, rm, wm, a1, ww, er);
        chk("esz_done", 32'(dc), 32'd1);
        chk("esz_err",  32'(er), 32'd1);
        chk("esz_mem",  32'({rm, wm}), 32'd0);
        run(1'b0, 2'b10, 1'b0, 32'h200, 0, dc, rm, wm, a1, ww, er);
        chk("eor_done", 32'(dc), 32'd1);
        chk("eor_err",  32'(er), 32'd1);
        chk("eor_mem",  32'({rm, wm}), 32'd0);
        chk("eor_data", bus.ls_rdata, 32'h00001234);

        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;

        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_size  = 2'b00;
        bus.ls_addr  = 32'h0C;
        bus.ls_wdata = 32'hEE;
        @(posedge clk); #1;
        bus.ls_req = 1'b0;
        @(posedge clk); #1;
        chk("rmw_mwr",  32'(bus.MemWrite), 32'd1);
        chk("rmw_wdat", bus.DM_Write_data, 32'h80FF12EE);
        rst = 1'b0;
        #1;
        chk("abt_mwr",  32'(bus.MemWrite), 32'd0);
        chk("abt_mrd",  32'(bus.MemRead),  32'd0);
        chk("abt_busy", 32'(bus.ls_busy),  32'd0);
        chk("abt_done", 32'(bus.ls_done),  32'd0);
        chk("abt_addr", 32'(bus.DM_addr),  32'd0);
        chk("abt_wdat", bus.DM_Write_data, 32'd0);
        chk("abt_rdat", bus.ls_rdata,      32'd0);
        @(posedge clk); #1;
        chk("abt_mem",  mem[3], 32'h80FF1234);
        rst = 1'b1;
        @(posedge clk); #1;
        run(1'b0, 2'b10, 1'b0, 32'h0C, 0, dc, rm, wm, a1, ww, er);
        chk("post_lw",  bus.ls_rdata, 32'h80FF1234);

        bus.ls_req      = 1'b1;
        bus.ls_we       = 1'b0;
        bus.ls_size     = 2'b10;
        bus.ls_unsigned = 1'b0;
        bus.ls_addr     = 32'h10;
        hold_rd = '0;
        hold_dn = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (bus.MemRead) hold_rd[c] = 1'b1;
            if (bus.ls_done) hold_dn[c] = 1'b1;
            if (c == 1) bus.ls_addr = 32'h14;
            if (c == 2) chk("hold_d1", bus.ls_rdata, 32'd4);
            if (c == 4) chk("hold_a2", 32'(bus.DM_addr), 32'd5);
            if (c == 5) begin
                chk("hold_d2", bus.ls_rdata, 32'd5);
                bus.ls_req = 1'b0;
            end
        end
        chk("hold_rd",  32'(hold_rd), 32'h12);
        chk("hold_dn",  32'(hold_dn), 32'h24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
